// File: rtl/lebug_pkg.sv
// rtl/lebug_pkg.sv - shared types and condition helper for the trace pipeline stages
//
// Purpose: common definitions used by the vector stages (vectorVectorALU,
// data_packer): condition codes, element type, config byte width and the
// condition evaluation function.
// Ports: none (package).
package lebug_pkg;

  localparam int CFG_BYTE_W = 8;
  localparam int ELEM_WIDTH = 32;

  typedef logic [ELEM_WIDTH-1:0] elem_t;

  typedef enum logic [CFG_BYTE_W-1:0] {
    COND_NONE     = 8'd0,
    COND_LAST     = 8'd1,
    COND_NOTLAST  = 8'd2,
    COND_FIRST    = 8'd3,
    COND_NOTFIRST = 8'd4
  } cond_t;

  // Unknown condition codes never fire, so a mis-programmed chain stays silent.
  function automatic logic cond_met(input logic [CFG_BYTE_W-1:0] cond,
                                    input logic eof, input logic bof);
    logic met;
    case (cond)
      COND_NONE:     met = 1'b1;
      COND_LAST:     met = eof;
      COND_NOTLAST:  met = ~eof;
      COND_FIRST:    met = bof;
      COND_NOTFIRST: met = ~bof;
      default:       met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/packer_shift_merge.sv
// rtl/packer_shift_merge.sv - combinational merge of pack buffer with incoming vector
//
// Purpose: given the pending pack buffer (fill elements valid) and a new
// vector of which len elements are kept, produce the emitted word (if the
// buffer reaches N elements) and the next buffer contents and fill.
// Ports:
//   pbuf_i      pending buffer, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fill_i      valid elements in pbuf_i (0..N-1)
//   vec_i       incoming vector, element 0 first
//   len_i       kept elements of vec_i (0..N)
//   out_word_o  full packed word, meaningful when emit_o
//   emit_o      buffer plus kept elements reached N
//   new_buf_o   next buffer contents (slots >= new_fill_o are don't-care)
//   new_fill_o  next fill
module packer_shift_merge #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic [N*DATA_WIDTH-1:0] pbuf_i,
  input  logic [$clog2(N)-1:0]    fill_i,
  input  logic [N*DATA_WIDTH-1:0] vec_i,
  input  logic [$clog2(N):0]      len_i,
  output logic [N*DATA_WIDTH-1:0] out_word_o,
  output logic                    emit_o,
  output logic [N*DATA_WIDTH-1:0] new_buf_o,
  output logic [$clog2(N)-1:0]    new_fill_o
);

  localparam int FILL_W = $clog2(N);
  localparam int TOT_W  = $clog2(N) + 2;

  logic [TOT_W-1:0] total;

  always_comb begin
    total      = TOT_W'(fill_i) + TOT_W'(len_i);
    emit_o     = (total >= TOT_W'(N));
    new_fill_o = emit_o ? FILL_W'(total - TOT_W'(N)) : FILL_W'(total);
    out_word_o = '0;
    new_buf_o  = '0;
    for (int i = 0; i < N; i++) begin
      // Buffered elements first, then the new vector shifted up by fill.
      if (i < int'(fill_i)) begin
        out_word_o[i*DATA_WIDTH +: DATA_WIDTH] = pbuf_i[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        out_word_o[i*DATA_WIDTH +: DATA_WIDTH] = vec_i[(i - int'(fill_i))*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (emit_o) begin
      // Remainder: elements N-fill.. of the new vector restart the buffer.
      for (int i = 0; i < N; i++) begin
        if ((N - int'(fill_i) + i) < N) begin
          new_buf_o[i*DATA_WIDTH +: DATA_WIDTH] = vec_i[(N - int'(fill_i) + i)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end else begin
      new_buf_o = out_word_o;
    end
  end

endmodule

// File: rtl/data_packer.sv
// rtl/data_packer.sv - keeps the first L elements per vector and packs them into N-element words
//
// Purpose: downstream of the vector-vector ALU; per-chain length and
// condition firmware, byte-serial config load, dense packing, flush of a
// partial word when tracing stops.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   tracing              1 = process stream, 0 = config mode
//   valid_in/eof_in/bof_in/chainId_in  input vector qualifiers
//   configId/configData  config target id and byte
//   vector_in            input elements, [0] first
//   vector_out           packed word, [0] oldest
//   valid_out            one-cycle pulse per packed word
module data_packer
  import lebug_pkg::*;
#(
  parameter int         N                     = 8,
  parameter int         DATA_WIDTH            = 32,
  parameter int         MAX_CHAINS            = 4,
  parameter int         PERSONAL_CONFIG_ID    = 0,
  parameter logic [7:0] INITIAL_FIRMWARE_LEN  [0:MAX_CHAINS-1] = '{default: 8'd0},
  parameter logic [7:0] INITIAL_FIRMWARE_COND [0:MAX_CHAINS-1] = '{default: 8'd0}
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                tracing,
  input  logic                                                valid_in,
  input  logic                                                eof_in,
  input  logic                                                bof_in,
  input  logic [((MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1)-1:0] chainId_in,
  input  logic [7:0]                                          configId,
  input  logic [7:0]                                          configData,
  input  logic [N*DATA_WIDTH-1:0]                             vector_in,
  output logic [N*DATA_WIDTH-1:0]                             vector_out,
  output logic                                                valid_out
);

  localparam int CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int FILL_W  = $clog2(N);
  localparam int LEN_W   = $clog2(N) + 1;

  logic [CFG_BYTE_W-1:0]   len_q  [0:MAX_CHAINS-1];
  logic [CFG_BYTE_W-1:0]   len_d  [0:MAX_CHAINS-1];
  logic [CFG_BYTE_W-1:0]   cond_q [0:MAX_CHAINS-1];
  logic [CFG_BYTE_W-1:0]   cond_d [0:MAX_CHAINS-1];
  logic [CFG_BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                    tracing_q;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [N*DATA_WIDTH-1:0] pbuf_q, pbuf_d;
  logic [N*DATA_WIDTH-1:0] vec_out_q, vec_out_d;
  logic                    valid_q, valid_d;

  logic [CFG_BYTE_W-1:0]   cur_len;
  logic [LEN_W-1:0]        eff_len;
  logic                    accept;
  logic                    flush;
  logic [N*DATA_WIDTH-1:0] flush_word;
  logic [N*DATA_WIDTH-1:0] sm_out;
  logic                    sm_emit;
  logic [N*DATA_WIDTH-1:0] sm_new_buf;
  logic [FILL_W-1:0]       sm_new_fill;

  assign cur_len = len_q[chainId_in];
  // Firmware may store lengths above N; they saturate to a full vector.
  assign eff_len = (cur_len > CFG_BYTE_W'(N)) ? LEN_W'(N) : LEN_W'(cur_len);
  assign accept  = tracing & valid_in & cond_met(cond_q[chainId_in], eof_in, bof_in);
  assign flush   = tracing_q & ~tracing & (fill_q != '0);

  always_comb begin
    flush_word = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(fill_q)) begin
        flush_word[i*DATA_WIDTH +: DATA_WIDTH] = pbuf_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  packer_shift_merge #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .pbuf_i     (pbuf_q),
    .fill_i     (fill_q),
    .vec_i      (vector_in),
    .len_i      (eff_len),
    .out_word_o (sm_out),
    .emit_o     (sm_emit),
    .new_buf_o  (sm_new_buf),
    .new_fill_o (sm_new_fill)
  );

  always_comb begin
    len_d      = len_q;
    cond_d     = cond_q;
    byte_cnt_d = byte_cnt_q;
    fill_d     = fill_q;
    pbuf_d     = pbuf_q;
    vec_out_d  = vec_out_q;
    valid_d    = 1'b0;

    if (!tracing) begin
      if (configId == CFG_BYTE_W'(PERSONAL_CONFIG_ID)) begin
        if (byte_cnt_q < CFG_BYTE_W'(MAX_CHAINS)) begin
          len_d[CHAIN_W'(byte_cnt_q)] = configData;
        end else if (byte_cnt_q < CFG_BYTE_W'(2*MAX_CHAINS)) begin
          cond_d[CHAIN_W'(byte_cnt_q - CFG_BYTE_W'(MAX_CHAINS))] = configData;
        end
        // Counter parks past the last slot so surplus bytes cannot wrap around.
        if (byte_cnt_q < CFG_BYTE_W'(2*MAX_CHAINS)) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end else begin
        byte_cnt_d = '0;
      end
    end

    if (flush) begin
      vec_out_d = flush_word;
      valid_d   = 1'b1;
      fill_d    = '0;
    end else if (accept && (eff_len != '0)) begin
      pbuf_d = sm_new_buf;
      fill_d = sm_new_fill;
      if (sm_emit) begin
        vec_out_d = sm_out;
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_CHAINS; i++) begin
        len_q[i]  <= INITIAL_FIRMWARE_LEN[i];
        cond_q[i] <= INITIAL_FIRMWARE_COND[i];
      end
      byte_cnt_q <= '0;
      tracing_q  <= 1'b0;
      fill_q     <= '0;
      pbuf_q     <= '0;
      vec_out_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      len_q      <= len_d;
      cond_q     <= cond_d;
      byte_cnt_q <= byte_cnt_d;
      tracing_q  <= tracing;
      fill_q     <= fill_d;
      pbuf_q     <= pbuf_d;
      vec_out_q  <= vec_out_d;
      valid_q    <= valid_d;
    end
  end

  assign vector_out = vec_out_q;
  assign valid_out  = valid_q;

endmodule
